led_matrix_scan: RTL and testbench
==================================

Name: led_matrix_scan

Overview:
- Scan driver directly upstream of the 2-4 matrix-select decoder in the LED display path.
- Holds a double-buffered frame image for 4 LED matrices of ROW_NUM x COL_NUM.
- Time-multiplexes the image: for each matrix and row, drives the 2-bit matrix select, decoder enable, one-hot row select and column data.
- Inserts a blanking gap between rows to suppress ghosting; swaps buffers only at frame boundaries, so no tearing.

Parameters:
- ROW_NUM, 8, rows per matrix; power of 2, 2..16.
- COL_NUM, 8, columns per matrix (width of column data).
- DWELL_CYCLES, 1000, clock cycles each row is lit; >=1.
- BLANK_CYCLES, 4, clock cycles of blanking before each row; >=1.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- scan_en_i  in  1  1 = run scanning; 0 = stop and blank.
- wr_en_i  in  1  write strobe into back buffer.
- wr_addr_i  in  2+log2(ROW_NUM)  {matrix[1:0], row}.
- wr_data_i  in  COL_NUM  column pattern for that row; 1 = LED on.
- swap_req_i  in  1  request back/front swap at next frame end.
- mat_sel_o  out  2  matrix index to the 2-4 decoder data input.
- decoder_en_o  out  1  decoder enable; 1 only while a row is lit.
- row_sel_o  out  ROW_NUM  one-hot active row; all 0 when blank.
- col_data_o  out  COL_NUM  column pattern of the lit row; 0 when blank.
- frame_done_o  out  1  1-cycle pulse at end of the last row of matrix 3.
- swap_ack_o  out  1  1-cycle pulse in the cycle the swap takes effect.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high.
- All outputs come from registers. There is no combinational path from any input to any output.
- Reset, including mid-scan: state goes to IDLE and the row/matrix/dwell counters clear.
  - All outputs go to 0.
  - Both buffers clear to 0, the front index goes to buffer 0, and any pending swap clears.
- FSM states:
  - IDLE: outputs blank. If scan_en_i=1, go to BLANK with mat=0, row=0 and the counter loaded.
  - BLANK: lasts BLANK_CYCLES cycles with decoder_en_o=0, row_sel_o=0, col_data_o=0. mat_sel_o already shows the upcoming matrix. Then go to DISPLAY.
  - DISPLAY: lasts DWELL_CYCLES cycles with decoder_en_o=1, mat_sel_o=mat, row_sel_o=1<<row, col_data_o=front[mat][row].
    - col_data_o is captured on entry and held stable for the whole dwell.
    - On the last dwell cycle, advance and return to BLANK.
- Advance order: row is the inner loop, matrix the outer.
  - row wraps ROW_NUM-1 -> 0 and increments mat.
  - mat wraps 3 -> 0. That is the frame end.
- Timing: if scan_en_i is sampled high in IDLE at cycle 0, BLANK occupies cycles 1..BLANK_CYCLES and DISPLAY begins at cycle BLANK_CYCLES+1.
  - Row period = BLANK_CYCLES + DWELL_CYCLES.
  - Frame period = 4*ROW_NUM*(BLANK_CYCLES + DWELL_CYCLES).
- Frame end: frame_done_o pulses in the last DISPLAY cycle of mat=3, row=ROW_NUM-1.
  - If a swap is pending in that cycle, the front index toggles, swap_ack_o pulses in the same cycle and the pending flag clears.
  - The first row of the next frame reads the new front buffer.
- swap_req_i sets the pending flag; repeated requests while pending merge into one. A swap_req_i in the swap cycle itself sets a new pending request.
- Writes always target the back buffer as indexed at the start of the cycle.
  - A write in the swap cycle lands in the buffer that becomes front.
  - Writes never disturb the row currently displayed.
- scan_en_i=0 in any state: go to IDLE next cycle, blank outputs and reset row/mat to 0. No frame_done_o pulse. A pending swap stays pending.
- Re-enabling scan_en_i always restarts at mat=0, row=0.
- Invariant: decoder_en_o=1 iff row_sel_o != 0. Never more than one row_sel_o bit is high.

Test Plan:
- Params ROW_NUM=8, DWELL_CYCLES=4, BLANK_CYCLES=2. Reset, then scan_en_i=1 at cycle 0 -> outputs 0 in cycles 1-2; cycles 3-6 show mat_sel_o=0, row_sel_o=8'h01, decoder_en_o=1, col_data_o=8'h00.
- Write {mat=2,row=5}=8'hA5, swap_req_i=1, run 2 frames -> swap_ack_o and frame_done_o coincide at cycle 192. In frame 2, while mat_sel_o=2 and row_sel_o=8'h20, col_data_o=8'hA5.
- Write a new value to the same address mid-frame without swap_req_i -> displayed data unchanged for the whole frame.
- swap_req_i asserted in the exact frame-end cycle of a pending swap -> one swap now and a second swap at the following frame end.
- scan_en_i dropped mid-DISPLAY (mat=1, row=3) -> next cycle all outputs 0. On re-enable, restart at mat=0, row=0 after 2 blank cycles.
- rst_i asserted mid-DISPLAY -> next cycle all outputs 0, FSM IDLE, buffers read back 0 after re-enable.

Source files
------------

// File: rtl/led_matrix_scan.sv
`default_nettype none
// ============================================================================
//  Module      : led_matrix_scan
//  Description : Scan driver for four ROW_NUM x COL_NUM LED matrices. Holds a
//                double-buffered frame image, lights one row at a time with a
//                blanking gap before each row, and swaps buffers only at the
//                frame boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_matrix_scan #(
  parameter int ROW_NUM      = 8,
  parameter int COL_NUM      = 8,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          scan_en_i,
  input  logic                          wr_en_i,
  input  logic [2+$clog2(ROW_NUM)-1:0]  wr_addr_i,
  input  logic [COL_NUM-1:0]            wr_data_i,
  input  logic                          swap_req_i,
  output logic [1:0]                    mat_sel_o,
  output logic                          decoder_en_o,
  output logic [ROW_NUM-1:0]            row_sel_o,
  output logic [COL_NUM-1:0]            col_data_o,
  output logic                          frame_done_o,
  output logic                          swap_ack_o
);

  localparam int c_RW    = $clog2(ROW_NUM);
  localparam int c_DEPTH = 4 * ROW_NUM;
  localparam int c_CMAX  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int c_CW    = (c_CMAX > 1) ? $clog2(c_CMAX) : 1;

  localparam logic [c_RW-1:0]    c_LAST_ROW = c_RW'(ROW_NUM - 1);
  localparam logic [c_CW-1:0]    c_BLANK_LD = c_CW'(BLANK_CYCLES - 1);
  localparam logic [c_CW-1:0]    c_DWELL_LD = c_CW'(DWELL_CYCLES - 1);
  localparam logic [ROW_NUM-1:0] c_ROW_ONE  = {{(ROW_NUM-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BLANK   = 2'd1,
    S_DISPLAY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [c_CW-1:0]    cnt_q, cnt_d;
  logic [c_RW-1:0]    row_q, row_d;
  logic [1:0]         mat_q, mat_d;
  logic               front_q;
  logic               pend_q, pend_d;

  // Two frame buffers; address is {matrix, row}
  logic [COL_NUM-1:0] mem_q [2][c_DEPTH];

  logic [1:0]         mat_sel_q, mat_sel_d;
  logic               dec_en_q, dec_en_d;
  logic [ROW_NUM-1:0] row_sel_q, row_sel_d;
  logic [COL_NUM-1:0] col_q, col_d;
  logic               frame_done_q, frame_done_d;
  logic               swap_ack_q, swap_ack_d;
  logic               disp_d;

  // Scan sequencing: next state, dwell/blank counter and row/matrix position
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    mat_d   = mat_q;
    if (!scan_en_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      row_d   = '0;
      mat_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          cnt_d   = c_BLANK_LD;
          row_d   = '0;
          mat_d   = '0;
        end
        S_BLANK: begin
          if (cnt_q == '0) begin
            state_d = S_DISPLAY;
            cnt_d   = c_DWELL_LD;
          end else begin
            cnt_d = cnt_q - c_CW'(1);
          end
        end
        S_DISPLAY: begin
          if (cnt_q == '0) begin
            state_d = S_BLANK;
            cnt_d   = c_BLANK_LD;
            if (row_q == c_LAST_ROW) begin
              row_d = '0;
              mat_d = mat_q + 2'd1;
            end else begin
              row_d = row_q + c_RW'(1);
            end
          end else begin
            cnt_d = cnt_q - c_CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          row_d   = '0;
          mat_d   = '0;
        end
      endcase
    end
  end

  // Output next-values derived from the upcoming state so every output is a flop
  always_comb begin
    disp_d       = (state_d == S_DISPLAY);
    mat_sel_d    = mat_d;
    dec_en_d     = disp_d;
    row_sel_d    = '0;
    col_d        = '0;
    frame_done_d = 1'b0;
    if (disp_d) begin
      row_sel_d = c_ROW_ONE << row_d;
      // Column data is latched once on entry and held for the whole dwell
      col_d     = (state_q == S_DISPLAY) ? col_q : mem_q[front_q][{mat_d, row_d}];
      frame_done_d = (cnt_d == '0) && (mat_d == 2'd3) && (row_d == c_LAST_ROW);
    end
    swap_ack_d = frame_done_d && (pend_q || swap_req_i);
    // A request arriving in the swap cycle itself survives as the next pending swap
    pend_d     = swap_ack_q ? swap_req_i : (pend_q || swap_req_i);
  end

  // State, counters, swap bookkeeping and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      mat_q        <= '0;
      front_q      <= 1'b0;
      pend_q       <= 1'b0;
      mat_sel_q    <= '0;
      dec_en_q     <= 1'b0;
      row_sel_q    <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
      swap_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      mat_q        <= mat_d;
      pend_q       <= pend_d;
      // The front index flips at the end of the cycle that shows swap_ack
      if (swap_ack_q) begin
        front_q <= ~front_q;
      end
      mat_sel_q    <= mat_sel_d;
      dec_en_q     <= dec_en_d;
      row_sel_q    <= row_sel_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
      swap_ack_q   <= swap_ack_d;
    end
  end

  // Frame buffer storage; writes always go to the current back buffer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < c_DEPTH; a++) begin
          mem_q[b][a] <= '0;
        end
      end
    end else if (wr_en_i) begin
      mem_q[~front_q][wr_addr_i] <= wr_data_i;
    end
  end

  assign mat_sel_o    = mat_sel_q;
  assign decoder_en_o = dec_en_q;
  assign row_sel_o    = row_sel_q;
  assign col_data_o   = col_q;
  assign frame_done_o = frame_done_q;
  assign swap_ack_o   = swap_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_matrix_scan
//  Description : Self-checking bench for led_matrix_scan: constant vector
//                table, directed swap/enable/reset sequences, and random
//                traffic compared against a slot-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_matrix_scan;

  localparam int ROW_NUM = 8;
  localparam int COL_NUM = 8;
  localparam int DWELL   = 4;
  localparam int BLANK   = 2;
  localparam int SLOT    = BLANK + DWELL;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       scan_en_i = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [4:0] wr_addr_i = '0;
  logic [7:0] wr_data_i = '0;
  logic       swap_req_i = 1'b0;
  logic [1:0] mat_sel_o;
  logic       decoder_en_o;
  logic [7:0] row_sel_o;
  logic [7:0] col_data_o;
  logic       frame_done_o;
  logic       swap_ack_o;

  led_matrix_scan #(
    .ROW_NUM(ROW_NUM), .COL_NUM(COL_NUM),
    .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .scan_en_i(scan_en_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .swap_req_i(swap_req_i), .mat_sel_o(mat_sel_o),
    .decoder_en_o(decoder_en_o), .row_sel_o(row_sel_o),
    .col_data_o(col_data_o), .frame_done_o(frame_done_o),
    .swap_ack_o(swap_ack_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [20:0] dut_pk;
  assign dut_pk = {mat_sel_o, decoder_en_o, row_sel_o, col_data_o, frame_done_o, swap_ack_o};

  // Reference model: position derived from cycles elapsed since scan start
  logic [7:0] mem_m [2][32];
  logic       fidx_m, pend_m, run_m;
  int         s_m;
  logic [7:0] colh_m;
  logic [1:0] m_mat;
  logic       m_dec, m_fd, m_ack;
  logic [7:0] m_rsel, m_col;
  logic [20:0] exp_pk;
  assign exp_pk = {m_mat, m_dec, m_rsel, m_col, m_fd, m_ack};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model(input logic r, e, w, input logic [4:0] a, input logic [7:0] d, input logic q);
    int p, slot, row, mat;
    logic [1:0] n_mat;
    logic       n_dec, n_fd;
    logic [7:0] n_rsel, n_col;
    if (r) begin
      for (int b = 0; b < 2; b++) for (int k = 0; k < 32; k++) mem_m[b][k] = '0;
      fidx_m = 0; pend_m = 0; run_m = 0; s_m = 0; colh_m = '0;
      m_mat = '0; m_dec = 0; m_rsel = '0; m_col = '0; m_fd = 0; m_ack = 0;
    end else begin
      if (!e) begin run_m = 0; s_m = 0; end
      else if (!run_m) begin run_m = 1; s_m = 1; end
      else s_m++;
      n_mat = '0; n_dec = 0; n_rsel = '0; n_col = '0; n_fd = 0;
      if (run_m) begin
        p    = (s_m - 1) % SLOT;
        slot = (s_m - 1) / SLOT;
        row  = slot % ROW_NUM;
        mat  = (slot / ROW_NUM) % 4;
        n_mat = 2'(mat);
        if (p >= BLANK) begin
          n_dec  = 1;
          n_rsel = 8'(1 << row);
          if (p == BLANK) colh_m = mem_m[fidx_m][mat * ROW_NUM + row];
          n_col  = colh_m;
          n_fd   = (p == SLOT - 1) && (row == ROW_NUM - 1) && (mat == 3);
        end
      end
      if (w) mem_m[!fidx_m][a] = d;
      if (m_ack) begin fidx_m = !fidx_m; pend_m = q; end
      else pend_m = pend_m | q;
      m_mat = n_mat; m_dec = n_dec; m_rsel = n_rsel; m_col = n_col;
      m_fd = n_fd; m_ack = n_fd && pend_m;
    end
  endtask

  task automatic step(input logic r, e, w, input logic [4:0] a, input logic [7:0] d, input logic q);
    rst_i = r; scan_en_i = e; wr_en_i = w; wr_addr_i = a; wr_data_i = d; swap_req_i = q;
    @(posedge clk_i);
    model(r, e, w, a, d, q);
    #1;
    cyc++;
    chk("model", {11'b0, dut_pk}, {11'b0, exp_pk});
  endtask

  typedef struct {
    logic       en;
    logic [1:0] mat;
    logic       dec;
    logic [7:0] rsel;
    logic [7:0] col;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int  o;
    logic found;
    logic [7:0] ev;

    tbl[0]  = '{1'b1, 2'd0, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 8'h00, 8'h00};
    tbl[2]  = '{1'b1, 2'd0, 1'b1, 8'h01, 8'h00};
    tbl[3]  = '{1'b1, 2'd0, 1'b1, 8'h01, 8'h00};
    tbl[4]  = '{1'b1, 2'd0, 1'b1, 8'h01, 8'h00};
    tbl[5]  = '{1'b1, 2'd0, 1'b1, 8'h01, 8'h00};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 8'h00, 8'h00};
    tbl[7]  = '{1'b1, 2'd0, 1'b0, 8'h00, 8'h00};
    tbl[8]  = '{1'b1, 2'd0, 1'b1, 8'h02, 8'h00};
    tbl[9]  = '{1'b1, 2'd0, 1'b1, 8'h02, 8'h00};
    tbl[10] = '{1'b1, 2'd0, 1'b1, 8'h02, 8'h00};
    tbl[11] = '{1'b1, 2'd0, 1'b1, 8'h02, 8'h00};
    tbl[12] = '{1'b0, 2'd0, 1'b0, 8'h00, 8'h00};
    tbl[13] = '{1'b1, 2'd0, 1'b0, 8'h00, 8'h00};
    tbl[14] = '{1'b1, 2'd0, 1'b0, 8'h00, 8'h00};
    tbl[15] = '{1'b1, 2'd0, 1'b1, 8'h01, 8'h00};

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_outputs", {11'b0, dut_pk}, 32'h0);

    // Start-up timing, row advance and disable/re-enable from the table
    for (int i = 0; i < 16; i++) begin
      step(0, tbl[i].en, 0, 0, 0, 0);
      chk("table", {13'b0, mat_sel_o, decoder_en_o, row_sel_o, col_data_o},
          {13'b0, tbl[i].mat, tbl[i].dec, tbl[i].rsel, tbl[i].col});
    end

    // Swap at frame end, stable display of mid-frame writes, back-to-back swap
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 5'd21, 8'hA5, 1);
    for (int c = 0; c < 900; c++) begin
      step(0, 1, (c == 250), 5'd21, 8'h3C, (c == 300) || (c == 384));
      o = c + 1;
      if (o == 192 || o == 384 || o == 576)
        chk("swap_at_frame_end", {30'b0, frame_done_o, swap_ack_o}, 32'h3);
      if (o == 191 || o == 193 || o == 383)
        chk("no_done_off_end", {30'b0, frame_done_o, swap_ack_o}, 32'h0);
      if (mat_sel_o == 2'd2 && row_sel_o == 8'h20) begin
        ev = (o <= 192) ? 8'h00 : (o <= 384) ? 8'hA5 : (o <= 576) ? 8'h3C : 8'hA5;
        chk("m2r5_data", {24'b0, col_data_o}, {24'b0, ev});
      end
    end

    // Drop enable while mat=1,row=3 is lit
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      step(0, 1, 0, 0, 0, 0);
      if (mat_sel_o == 2'd1 && row_sel_o == 8'h08) found = 1;
    end
    chk("find_m1r3", {31'b0, found}, 32'h1);
    step(0, 0, 0, 0, 0, 0);
    chk("disable_blank", {11'b0, dut_pk}, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("reenable_blank1", {21'b0, mat_sel_o, decoder_en_o, row_sel_o}, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("reenable_blank2", {21'b0, mat_sel_o, decoder_en_o, row_sel_o}, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("reenable_m0r0", {21'b0, mat_sel_o, decoder_en_o, row_sel_o}, {21'b0, 2'd0, 1'b1, 8'h01});

    // Reset mid-display clears everything including both buffers
    step(1, 1, 0, 0, 0, 0);
    chk("rst_mid_display", {11'b0, dut_pk}, 32'h0);
    for (int k = 0; k < 200; k++) begin
      step(0, 1, 0, 0, 0, 0);
      if (decoder_en_o) chk("cleared_buffer", {24'b0, col_data_o}, 32'h0);
    end

    // Random traffic against the reference model
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 1499) == 0),
           ($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) < 3),
           5'($urandom_range(0, 31)),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
